// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if: SPI pins plus the system-side word/status bus of the SPI slave
interface spi_slave_sync_if #(parameter int DATA_WIDTH = 16);
  logic sclk;
  logic ss;
  logic mosi;
  logic miso;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic rx_valid;
  logic frame_err;
  logic busy;
  modport slave (input sclk, ss, mosi, data_in, output miso, data_out, rx_valid, frame_err, busy);
  modport master (output sclk, ss, mosi, data_in, input miso, data_out, rx_valid, frame_err, busy);
endinterface

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: mode-0 SPI slave oversampled on clk, full-duplex word shift with frame error detection
module spi_slave_sync #(
  parameter int DATA_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  spi_slave_sync_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q, flush;
  logic sclk_s, ss_s, mosi_s, sclk_d, ss_d, armed, done;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, start, abort, last, to_idle;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, data_out;
  logic [CW-1:0] bit_cnt;
  logic miso, rx_valid, frame_err, busy;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ss_s = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise = ss_s & ~ss_d;
  assign ss_fall = ~ss_s & ss_d;
  // a low ss still flushing out of the synchronizer after reset must not look like a frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      ss_q <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      ss_d <= 1'b1;
      flush <= '0;
      armed <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
      ss_q <= {ss_q[SYNC_STAGES-2:0], bus.ss};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_d <= sclk_s;
      ss_d <= ss_s;
      flush <= {flush[SYNC_STAGES-2:0], 1'b1};
      armed <= armed | (flush[SYNC_STAGES-1] & ss_s);
    end
  end
  assign start = (state == IDLE) & ss_fall & armed;
  assign abort = (state == SHIFT) & ss_rise;
  assign last = (state == SHIFT) & ~ss_rise & sclk_rise & (bit_cnt == CW'(DATA_WIDTH - 1));
  assign to_idle = abort | ((state == WAIT_END) & ss_rise);
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = start ? SHIFT : to_idle ? IDLE : last ? WAIT_END : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '0;
      rx_shift <= '0;
      data_out <= '0;
      bit_cnt <= '0;
      miso <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done <= last;
      rx_valid <= done;
      frame_err <= abort;
      if (done) data_out <= rx_shift;
      if (start) begin
        tx_shift <= bus.data_in;
        bit_cnt <= '0;
        miso <= bus.data_in[DATA_WIDTH-1];
        busy <= 1'b1;
      end else if (to_idle) begin
        miso <= 1'b0;
        busy <= 1'b0;
      end else if ((state == SHIFT) & sclk_rise) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        bit_cnt <= bit_cnt + 1'b1;
      end else if ((state == SHIFT) & sclk_fall & (bit_cnt < CW'(DATA_WIDTH))) begin
        tx_shift <= tx_shift << 1;
        miso <= tx_shift[DATA_WIDTH-2];
      end
    end
  end
  assign bus.miso = miso;
  assign bus.data_out = data_out;
  assign bus.rx_valid = rx_valid;
  assign bus.frame_err = frame_err;
  assign bus.busy = busy;
endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Clock-domain-aware SPI slave, the receive/respond end of the team's 16-bit SPI master link. Unlike a slave clocked directly by `sclk`, it runs entirely on the system clock: it oversamples `sclk`, `ss` and `mosi` through synchronizers, detects edges and shifts one full-duplex 16-bit word per frame. It presents received words to system logic with a one-cycle valid pulse and flags frames that end early.

## Interface
- `DATA_WIDTH`, 16: word length in bits. MSB first.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `sclk`, `ss` and `mosi`. Must be at least 2.

- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from the master. Asynchronous to `clk`. Idles low.
- `ss`  in  1  slave select. Active low. Asynchronous.
- `mosi`  in  1  serial data from the master. Asynchronous.
- `miso`  out  1  serial data to the master. Registered.
- `data_in`  in  DATA_WIDTH  word to transmit. Sampled at frame start.
- `data_out`  out  DATA_WIDTH  last complete received word. Held until the next complete frame.
- `rx_valid`  out  1  one-cycle pulse when `data_out` updates.
- `frame_err`  out  1  one-cycle pulse when `ss` deasserts mid-word.
- `busy`  out  1  high from frame start detection until return to IDLE.

## Operation
- SPI mode 0: CPOL=0, CPHA=0.
  - The slave samples `mosi` on `sclk` rising.
  - It advances `miso` on `sclk` falling.
- `sclk`, `ss` and `mosi` each pass through `SYNC_STAGES` flops, giving `sclk_s`, `ss_s` and `mosi_s`. All three have equal delay, so the data/clock relationship is preserved.
- Edge detect uses one extra register per signal:
  - rise = s & ~d
  - fall = ~s & d
- FSM states: IDLE, SHIFT, WAIT_END.
  - IDLE to SHIFT on `ss_s` fall. On that cycle: tx_shift <= `data_in`, bit_cnt <= 0, `miso` <= `data_in[MSB]`, `busy` <= 1.
  - SHIFT, on `sclk_s` rise: rx_shift <= {rx_shift[DATA_WIDTH-2:0], `mosi_s`}, bit_cnt++.
  - SHIFT, on `sclk_s` fall with bit_cnt < DATA_WIDTH: tx_shift <<= 1, `miso` <= next bit (new tx_shift MSB).
  - SHIFT to WAIT_END on the rise that makes bit_cnt = DATA_WIDTH. On that cycle's next edge: `data_out` <= completed word (including the bit just sampled), and `rx_valid` = 1 for exactly one cycle.
  - SHIFT, on `ss_s` rise with bit_cnt < DATA_WIDTH: `frame_err` pulses one cycle, state goes to IDLE, `data_out` is unchanged, no `rx_valid`.
  - WAIT_END: `sclk_s` edges are ignored and `miso` holds. On `ss_s` rise, go to IDLE.
- On entry to IDLE, `busy` <= 0 and `miso` <= 0.
- If `ss_s` rise and `sclk_s` rise occur on the same cycle in SHIFT, `ss` wins. The edge is not sampled, and the frame is an error unless bit_cnt already equals DATA_WIDTH.
- `data_in` is sampled only at frame start. Changes during a frame have no effect.
- Synchronous reset, any state:
  - All registers cleared and state = IDLE.
  - Outputs after reset: `miso`=0, `data_out`=0, `rx_valid`=0, `frame_err`=0, `busy`=0.
  - A frame in progress is abandoned.
  - If `ss` is still low when reset releases, no frame starts until a fresh `ss` fall is seen. The synchronizer and edge registers reset to the idle levels `ss`=1, `sclk`=0.

## Timing
- Detection latency: SYNC_STAGES+1 `clk` cycles from an input pin change to the corresponding state update (3 cycles at default).
- `rx_valid` asserts 4 cycles after the 16th `sclk` rising at the pin (default configuration).
- `miso` is updated 3 cycles after an `sclk` falling pin edge. The master samples half an `sclk` period later.
- Requirement: `sclk` high and low phases are each ≥ 4 `clk` periods. `ss` fall to first `sclk` rise is ≥ 4 `clk` periods, so `miso` MSB is valid before the first sample.
- Throughput: one word per `ss` frame. Back-to-back frames need `ss` high for ≥ 2 `clk` cycles.

## Test plan
- Reset then idle: `rst` high 3 cycles, `ss`=1 → all outputs 0, `busy`=0; no pulses for 100 cycles.
- Full duplex: `data_in`=16'hA55A, master sends 16'h3C96 with `sclk` period 10 `clk` →
  - master receives 16'hA55A;
  - `data_out`=16'h3C96;
  - exactly one `rx_valid` pulse;
  - `busy` falls after `ss` rises.
- Short frame: 7 `sclk` pulses then `ss` high → one `frame_err` pulse; `data_out` keeps its previous value (16'h3C96); no `rx_valid`; state IDLE.
- Back-to-back frames: 16'h0001 then 16'hFFFF, `ss` high 2 cycles between → two `rx_valid` pulses, with `data_out` 16'h0001 then 16'hFFFF. `miso` carries the `data_in` captured at each frame start.
- Reset mid-frame: assert `rst` after 9 bits, release with `ss` still low and clocks continuing → no `rx_valid` or `frame_err`; `busy`=0. The next proper frame (16'h1234) is received correctly.
- Extra clocks: 18 `sclk` pulses in one frame → `data_out` = first 16 bits; one `rx_valid`; `miso` holds during the extra pulses.
